// File: rtl/sail_hex_bits_parser.sv
// rtl/sail_hex_bits_parser.sv - streaming parser of Sail "0x..." hex literals into an N-bit value
module sail_hex_bits_parser #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_bits,
  output logic         out_ok
);

  typedef enum logic [2:0] {P0, PX, DIG, DRAIN, DONE} state_t;

  state_t       state, state_n;
  logic [N-1:0] acc, acc_n, bits_n;
  logic         ovf, ovf_n, ok_n;
  logic         beat, err, is_hex, ovf_dig;
  logic [3:0]   nib;
  logic [N+3:0] shifted;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign beat      = in_valid && in_ready;

  always_comb begin
    is_hex = 1'b1;
    nib    = 4'd0;
    if (in_byte >= 8'h30 && in_byte <= 8'h39)
      nib = in_byte[3:0];
    else if ((in_byte >= 8'h41 && in_byte <= 8'h46) || (in_byte >= 8'h61 && in_byte <= 8'h66))
      nib = in_byte[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

  // Bits shifted above N are significant, so they latch overflow; leading zeros never do.
  assign shifted = {acc, nib};
  assign ovf_dig = ovf | (|shifted[N+3:N]);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf;
    bits_n  = out_bits;
    ok_n    = out_ok;
    err     = 1'b0;
    case (state)
      P0: if (beat) begin
        if (in_byte == 8'h30 && !in_last) state_n = PX;
        else                              err = 1'b1;
      end
      PX: if (beat) begin
        if (in_byte == 8'h78 && !in_last) begin
          state_n = DIG;
          acc_n   = '0;
          ovf_n   = 1'b0;
        end else begin
          err = 1'b1;
        end
      end
      DIG: if (beat) begin
        if (is_hex) begin
          acc_n = shifted[N-1:0];
          ovf_n = ovf_dig;
          if (in_last) begin
            state_n = DONE;
            ok_n    = !ovf_dig;
            bits_n  = ovf_dig ? '0 : shifted[N-1:0];
          end
        end else begin
          err = 1'b1;
        end
      end
      DRAIN: if (beat && in_last) begin
        state_n = DONE;
        ok_n    = 1'b0;
        bits_n  = '0;
      end
      DONE: if (out_ready) state_n = P0;
      default: state_n = P0;
    endcase
    if (err) begin
      ok_n    = 1'b0;
      bits_n  = '0;
      state_n = in_last ? DONE : DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= P0;
      acc      <= '0;
      ovf      <= 1'b0;
      out_bits <= '0;
      out_ok   <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      ovf      <= ovf_n;
      out_bits <= bits_n;
      out_ok   <= ok_n;
    end
  end

endmodule

// File: tb/tb_sail_hex_bits_parser.sv
// tb/tb_sail_hex_bits_parser.sv - checks parser at N=8,5,1 against a string-level reference model
module tb_sail_hex_bits_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       rdy8, rdy5, rdy1, ov8, ov5, ov1, ok8, ok5, ok1;
  logic [7:0] bits8;
  logic [4:0] bits5;
  logic [0:0] bits1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // All widths see the same stream; framing never depends on N, so they stay in lockstep.
  sail_hex_bits_parser #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_byte(in_byte), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready), .out_bits(bits8), .out_ok(ok8));
  sail_hex_bits_parser #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy5),
    .in_byte(in_byte), .in_last(in_last), .out_valid(ov5), .out_ready(out_ready), .out_bits(bits5), .out_ok(ok5));
  sail_hex_bits_parser #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_byte(in_byte), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_bits(bits1), .out_ok(ok1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Reference: validate the literal textually, then judge width by counting significant bits.
  function automatic void model(input string s, input int n, output logic ok, output logic [63:0] val);
    int f, d, nbits, top;
    ok = 1'b0;
    val = '0;
    if (s.len() < 3 || s[0] != "0" || s[1] != "x") return;
    for (int i = 2; i < s.len(); i++)
      if (hexval(s[i]) < 0) return;
    f = 2;
    while (f < s.len() && s[f] == "0") f++;
    d = s.len() - f;
    if (d == 0) begin
      ok = 1'b1;
      return;
    end
    top = hexval(s[f]);
    nbits = 4 * (d - 1);
    while (top > 0) begin
      nbits++;
      top = top / 2;
    end
    if (nbits > n) return;
    ok = 1'b1;
    for (int i = f; i < s.len(); i++) val = val * 16 + 64'(hexval(s[i]));
  endfunction

  task automatic send(input string s, input int gap, input bit mark_last);
    int t;
    for (int i = 0; i < s.len(); i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'hxx;
        @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = s[i];
      in_last  = mark_last && (i == s.len() - 1);
      t = 0;
      while (!rdy8 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) chk({s, " beat timeout"}, 64'(rdy8), 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input string s);
    logic ok;
    logic [63:0] v;
    model(s, 8, ok, v);
    chk({s, " valid8"}, 64'(ov8), 64'd1);
    chk({s, " ok8"},    64'(ok8), 64'(ok));
    chk({s, " bits8"},  64'(bits8), v);
    model(s, 5, ok, v);
    chk({s, " valid5"}, 64'(ov5), 64'd1);
    chk({s, " ok5"},    64'(ok5), 64'(ok));
    chk({s, " bits5"},  64'(bits5), v);
    model(s, 1, ok, v);
    chk({s, " valid1"}, 64'(ov1), 64'd1);
    chk({s, " ok1"},    64'(ok1), 64'(ok));
    chk({s, " bits1"},  64'(bits1), v);
  endtask

  task automatic accept;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid after accept", 64'(ov8), 64'd0);
    chk("ready after accept", 64'(rdy8), 64'd1);
  endtask

  task automatic run(input string s, input int gap);
    send(s, gap, 1'b1);
    check_out(s);
    accept();
  endtask

  function automatic string rand_str();
    string hexc = "0123456789abcdefABCDEF";
    string badc = "gXz0 x";
    string s = "0x", r = "";
    int nz = $urandom_range(0, 3);
    int nd = $urandom_range(0, 3);
    int p;
    for (int i = 0; i < nz; i++) s = {s, "0"};
    for (int i = 0; i < nd; i++) s = $sformatf("%s%c", s, hexc[$urandom_range(0, 21)]);
    if ($urandom_range(0, 5) == 0) begin
      p = $urandom_range(0, s.len() - 1);
      for (int i = 0; i < s.len(); i++)
        r = $sformatf("%s%c", r, (i == p) ? badc[$urandom_range(0, 5)] : s[i]);
      s = r;
    end
    return s;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset valid", 64'(ov8), 64'd0);
    chk("reset ok",    64'(ok8), 64'd0);
    chk("reset bits",  64'(bits8), 64'd0);
    chk("reset ready", 64'(rdy8), 64'd1);

    run("0xff", 0);
    run("0x000A5", 0);
    run("0x1ff", 0);
    run("0x", 0);
    run("0X1", 0);
    run("0", 0);
    run("0xg1", 0);
    run("0x3", 0);
    run("0x1F", 0);
    run("0x20", 0);
    run("0x1", 0);
    run("0x2", 0);
    run("0x0000", 0);
    run("0xA", 2);

    // Result held under backpressure while a "0" waits on the input.
    send("0x7", 0, 1'b1);
    check_out("0x7");
    in_valid = 1'b1;
    in_byte  = "0";
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold valid", 64'(ov8), 64'd1);
      chk("hold bits",  64'(bits8), 64'h07);
      chk("hold ok",    64'(ok8), 64'd1);
      chk("hold ready", 64'(rdy8), 64'd0);
    end
    accept();
    @(posedge clk);
    send("x3", 0, 1'b1);
    check_out("0x3");
    accept();

    // Reset mid-string abandons it.
    send("0x1", 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst valid", 64'(ov8), 64'd0);
    chk("rst ready", 64'(rdy8), 64'd1);
    run("0x5", 0);

    for (int k = 0; k < 40; k++) run(rand_str(), $urandom_range(0, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sail_hex_bits_parser.md
Name: sail_hex_bits_parser

Overview:
- Streaming reader for Sail hex bitvector literals: consumes an ASCII byte stream one character per beat and produces an N-bit value plus a validity flag.
- Acceptance rules match the combinational hex-literal validity check: lowercase "0x" prefix, at least one digit, only [0-9A-Fa-f], leading zeros ignored, significant width <= N.
- Sits between a string/stdin byte source and Sail-generated logic that needs bitvector values parsed from text.

Parameters:
- N, 64, output bitvector width; legal range N >= 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  character beat valid
- in_ready  output  1  parser can accept a character
- in_byte  input  8  ASCII character
- in_last  input  1  final character of the current string
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_bits  output  N  parsed value; 0 when out_ok=0
- out_ok  output  1  1 = string is a valid N-bit hex literal

Behaviour:
- One clock. Reset is synchronous and active-low.
- Beat transfer: in_valid && in_ready at a rising edge. Result transfer: out_valid && out_ready at a rising edge.
- Reset values: state=P0, out_valid=0, out_bits=0, out_ok=0, accumulator=0, overflow=0. in_ready=1 after reset.
- in_ready is 1 in P0, PX, DIG and DRAIN; it is 0 in DONE.

States and transitions:
- P0: waiting for "0".
  - Byte=="0" (0x30) and !in_last -> PX.
  - Any other byte, or in_last -> error.
- PX: waiting for "x".
  - Byte=="x" (0x78) and !in_last -> DIG, with acc=0 and ovf=0.
  - "X" is an error. in_last is an error (covers "0x").
  - Any other byte is an error.
- DIG: accumulating digits.
  - Hex digit: acc' = {acc,nib} held in an (N+4)-bit register.
  - ovf' = ovf | (|acc'[N+3:N]); then acc'[N+3:N] is cleared.
  - in_last with a hex digit -> DONE, out_ok = !ovf', out_bits = ovf' ? 0 : acc'[N-1:0].
  - Non-hex byte -> error.
- Error handling:
  - Error on a beat with in_last=1 -> DONE, out_ok=0, out_bits=0.
  - Error on a beat with in_last=0 -> DRAIN.
- DRAIN: discard beats. The beat with in_last=1 -> DONE, out_ok=0, out_bits=0.
- DONE: out_valid=1.
  - out_bits and out_ok stay stable until the result is accepted.
  - On accept -> P0, out_valid=0 the next cycle.
  - No input is accepted in the acceptance cycle.

Timing and boundary rules:
- Latency: out_valid rises the cycle after the in_last beat is accepted. Minimum string "0x0" = 3 beats, so the result appears at cycle 4.
- Leading zeros never set ovf, e.g. "0x0000" with N=1 gives ok=1, bits=0.
- Overflow is judged on significant bits only. With N=5, "0x1f" is ok (bits=0x1F) and "0x2f" overflows.
- The accumulator keeps running after overflow, but the output is forced to 0.
- in_valid=0 cycles inside a string are idle and change no state.
- in_byte and in_last are ignored when in_valid=0.
- rst_n low in any state: the partial string is abandoned, state returns to P0 and out_valid clears on that edge. The rest of the abandoned string is parsed as a new string, so the bench must not continue a string across reset.

Test Plan:
- N=8, stream "0xff" (last on "f"), out_ready=1 -> out_valid 1 cycle after last beat, out_ok=1, out_bits=0xFF, back to in_ready=1 next cycle.
- N=8, stream "0x000A5" then "0x1ff" -> first: ok=1, bits=0xA5 (leading zeros ignored); second: ok=0, bits=0x00 (9 significant bits).
- N=8, strings "0x", "0X1", "0" and "0xg1" -> all give ok=0, bits=0.
  - "0xg1": exactly 4 beats consumed; DRAIN swallows "1".
  - Next string "0x3" parses to ok=1, bits=0x03.
- N=5, "0x1F" -> ok=1, bits=0x1F; "0x20" -> ok=0. N=1, "0x1" -> ok=1, bits=1; "0x2" -> ok=0.
- Backpressure: "0x7" with out_ready=0 for 3 cycles -> out_valid, bits=0x07 and ok=1 held stable; in_ready=0 throughout; a presented "0" beat is not consumed until after accept.
- Gaps and reset: "0xA" with in_valid low 2 cycles between beats -> bits=0x0A. Reset asserted after "0x1" of "0x12" -> out_valid=0, state P0; following "0x5" gives bits=0x05.
